// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
//   CNT_WRAP / CNT_SAT : end-of-range behaviour selectors for the SATURATE parameter
//   is_legal_modulus   : elaboration-time check that 2 <= modulus <= 2**width
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // A modulus is usable when the range has at least two states and fits in width bits.
  function automatic bit is_legal_modulus(input int width, input longint modulus);
    bit ok_v;
    if ((width < 1) || (width > 31)) begin
      ok_v = 1'b0;
    end else begin
      ok_v = (modulus >= 64'sd2) && (modulus <= (64'sd1 <<< width));
    end
    return ok_v;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the modulo-N up/down counter.
//   slave  : counter side (receives controls, returns count and flags)
//   master : controller side
//   CountEn, Up, Load, LoadVal, OutEn : controls
//   Count, TC, Wrapped, LoadErr        : status
interface mod_updown_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             CountEn;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadVal;
  logic             OutEn;
  logic [WIDTH-1:0] Count;
  logic             TC;
  logic             Wrapped;
  logic             LoadErr;

  modport slave (
    input  CountEn, Up, Load, LoadVal, OutEn,
    output Count, TC, Wrapped, LoadErr
  );

  modport master (
    output CountEn, Up, Load, LoadVal, OutEn,
    input  Count, TC, Wrapped, LoadErr
  );

endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate mode,
// cascade terminal count and a tri-state copy of the count.
//   Clock  : rising-edge clock
//   Reset  : synchronous, active-high
//   bus    : control/status bundle (slave side)
//   Q      : tri-state count bus, driven only while bus.OutEn is high
// Priority per edge: Reset > Load > CountEn > hold.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 13,
  parameter int SATURATE = CNT_WRAP
)(
  input  logic                  Clock,
  input  logic                  Reset,
  mod_updown_counter_if.slave   bus,
  output wire  [WIDTH-1:0]      Q
);

  localparam logic [WIDTH-1:0] ZERO_C    = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the load range check.
  localparam logic [WIDTH:0]   MOD_EXT_C = (WIDTH + 1)'(MODULUS);
  localparam bit               SAT_C     = (SATURATE == CNT_SAT);

  if (!is_legal_modulus(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if ((SATURATE != CNT_WRAP) && (SATURATE != CNT_SAT)) begin : g_bad_mode
    $error("mod_updown_counter: SATURATE must be CNT_WRAP or CNT_SAT");
  end

  logic [WIDTH-1:0] count_r;
  logic             wrapped_r;
  logic             load_err_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             at_end_s;
  logic             load_ok_s;

  // Next count for a counting cycle and detection of the range end in the current direction.
  always_comb begin
    count_nxt_s = count_r;
    at_end_s    = 1'b0;
    load_ok_s   = ({1'b0, bus.LoadVal} < MOD_EXT_C);
    if (bus.Up) begin
      at_end_s = (count_r == MAX_C);
      if (at_end_s) begin
        count_nxt_s = SAT_C ? count_r : ZERO_C;
      end else begin
        count_nxt_s = count_r + ONE_C;
      end
    end else begin
      at_end_s = (count_r == ZERO_C);
      if (at_end_s) begin
        count_nxt_s = SAT_C ? count_r : MAX_C;
      end else begin
        count_nxt_s = count_r - ONE_C;
      end
    end
  end

  // Count register and the one-cycle event flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r    <= ZERO_C;
      wrapped_r  <= 1'b0;
      load_err_r <= 1'b0;
    end else if (bus.Load) begin
      // Out-of-range loads clamp to the top of the range and flag the error.
      count_r    <= load_ok_s ? bus.LoadVal : MAX_C;
      wrapped_r  <= 1'b0;
      load_err_r <= ~load_ok_s;
    end else if (bus.CountEn) begin
      count_r    <= count_nxt_s;
      wrapped_r  <= at_end_s;
      load_err_r <= 1'b0;
    end else begin
      wrapped_r  <= 1'b0;
      load_err_r <= 1'b0;
    end
  end

  // Terminal count is combinational so a cascaded stage advances on the same edge.
  assign bus.TC      = bus.CountEn & ~Reset & ~bus.Load & at_end_s;
  assign bus.Count   = count_r;
  assign bus.Wrapped = wrapped_r;
  assign bus.LoadErr = load_err_r;
  assign Q           = bus.OutEn ? count_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: wrap (MOD 13), saturate (MOD 13)
// and a two-stage MOD 16 cascade. The stimulus pushes hand-derived expected
// values; a negedge monitor pops and compares. Q buses are pulled high so a
// released bus reads all ones.
module tb_mod_updown_counter;
  import counter_pkg::*;

  typedef struct {
    int         unit;
    logic [7:0] cnt;
    logic       tc;
    logic       w;
    logic       le;
    int         qm;   // 0: skip Q, 1: Q equals count, 2: Q released (pulled high)
    string      name;
  } exp_t;

  logic Clock;
  logic rst_a, rst_b, rst_c;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] dn_vals [6];

  mod_updown_counter_if #(.WIDTH(4)) if_a ();
  mod_updown_counter_if #(.WIDTH(4)) if_b ();
  mod_updown_counter_if #(.WIDTH(4)) if_lo ();
  mod_updown_counter_if #(.WIDTH(4)) if_hi ();

  tri1 [3:0] q_a;
  tri1 [3:0] q_b;
  tri1 [3:0] q_lo;
  tri1 [3:0] q_hi;

  mod_updown_counter #(.WIDTH(4), .MODULUS(13), .SATURATE(CNT_WRAP)) dut_a (
    .Clock(Clock), .Reset(rst_a), .bus(if_a), .Q(q_a));
  mod_updown_counter #(.WIDTH(4), .MODULUS(13), .SATURATE(CNT_SAT)) dut_b (
    .Clock(Clock), .Reset(rst_b), .bus(if_b), .Q(q_b));
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(CNT_WRAP)) dut_lo (
    .Clock(Clock), .Reset(rst_c), .bus(if_lo), .Q(q_lo));
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(CNT_WRAP)) dut_hi (
    .Clock(Clock), .Reset(rst_c), .bus(if_hi), .Q(q_hi));

  assign if_hi.CountEn = if_lo.TC;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check_field(input string name, input string field,
                             input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s actual=%0h expected=%0h", name, field, act, exp);
    end
  endtask

  always @(negedge Clock) begin : monitor
    exp_t e;
    logic [7:0] c, q;
    logic tc, w, le;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.unit)
        0: begin
          c = {4'h0, if_a.Count}; q = {4'h0, q_a};
          tc = if_a.TC; w = if_a.Wrapped; le = if_a.LoadErr;
        end
        1: begin
          c = {4'h0, if_b.Count}; q = {4'h0, q_b};
          tc = if_b.TC; w = if_b.Wrapped; le = if_b.LoadErr;
        end
        default: begin
          c = {if_hi.Count, if_lo.Count}; q = {q_hi, q_lo};
          tc = if_hi.TC; w = if_hi.Wrapped; le = if_hi.LoadErr | if_lo.LoadErr;
        end
      endcase
      check_field(e.name, "Count",   c,            e.cnt);
      check_field(e.name, "TC",      {7'h00, tc},  {7'h00, e.tc});
      check_field(e.name, "Wrapped", {7'h00, w},   {7'h00, e.w});
      check_field(e.name, "LoadErr", {7'h00, le},  {7'h00, e.le});
      if (e.qm == 1) begin
        check_field(e.name, "Q", q, e.cnt);
      end else if (e.qm == 2) begin
        check_field(e.name, "Q", q, 8'h0F);
      end
    end
  end

  // Push one expectation for the state after the coming edge, then move to the next cycle.
  task automatic ex(input int unit, input logic [7:0] cnt, input logic tc, input logic w,
                    input logic le, input int qm, input string name);
    exp_t e;
    e.unit = unit; e.cnt = cnt; e.tc = tc; e.w = w; e.le = le; e.qm = qm; e.name = name;
    exp_q.push_back(e);
    @(negedge Clock);
    #1;
  endtask

  task automatic set_a(input logic cen, input logic up, input logic ld,
                       input logic [3:0] lv, input logic oe);
    if_a.CountEn = cen; if_a.Up = up; if_a.Load = ld; if_a.LoadVal = lv; if_a.OutEn = oe;
  endtask

  task automatic set_b(input logic cen, input logic up, input logic ld,
                       input logic [3:0] lv, input logic oe);
    if_b.CountEn = cen; if_b.Up = up; if_b.Load = ld; if_b.LoadVal = lv; if_b.OutEn = oe;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    set_a(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    set_b(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    if_lo.CountEn = 1'b0; if_lo.Up = 1'b1; if_lo.Load = 1'b0; if_lo.LoadVal = 4'h0; if_lo.OutEn = 1'b1;
    if_hi.Up = 1'b1; if_hi.Load = 1'b0; if_hi.LoadVal = 4'h0; if_hi.OutEn = 1'b1;
    dn_vals[0] = 8'd4; dn_vals[1] = 8'd3; dn_vals[2] = 8'd2;
    dn_vals[3] = 8'd1; dn_vals[4] = 8'd0; dn_vals[5] = 8'd12;
    @(negedge Clock);
    #1;

    // ---- wrap counter, MOD 13 ----
    ex(0, 8'd0, 1'b0, 1'b0, 1'b0, 1, "a_reset");
    rst_a = 1'b0;
    set_a(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      ex(0, 8'((i + 1) % 13), ((i + 1) % 13) == 12, i == 12, 1'b0, 1, "a_up");
    end
    set_a(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ex(0, 8'(2 + i), 1'b0, 1'b0, 1'b0, 2, "a_hiz");
    end
    set_a(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    ex(0, 8'd4, 1'b0, 1'b0, 1'b0, 1, "a_oe_back");
    set_a(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
    ex(0, 8'd5, 1'b0, 1'b0, 1'b0, 1, "a_load5");
    set_a(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ex(0, dn_vals[i], dn_vals[i] == 8'd0, dn_vals[i] == 8'd12, 1'b0, 1, "a_down");
    end
    set_a(1'b1, 1'b0, 1'b1, 4'd14, 1'b1);
    ex(0, 8'd12, 1'b0, 1'b0, 1'b1, 1, "a_load14_err");
    set_a(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    ex(0, 8'd12, 1'b0, 1'b0, 1'b0, 1, "a_err_clear");
    set_a(1'b0, 1'b0, 1'b1, 4'd13, 1'b1);
    ex(0, 8'd12, 1'b0, 1'b0, 1'b1, 1, "a_load13_err");
    set_a(1'b1, 1'b1, 1'b1, 4'd12, 1'b1);
    ex(0, 8'd12, 1'b0, 1'b0, 1'b0, 1, "a_load12_tc_masked");
    set_a(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    ex(0, 8'd0, 1'b0, 1'b1, 1'b0, 1, "a_wrap_after_load");
    set_a(1'b0, 1'b1, 1'b1, 4'd6, 1'b1);
    ex(0, 8'd6, 1'b0, 1'b0, 1'b0, 1, "a_load6");
    set_a(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    ex(0, 8'd7, 1'b0, 1'b0, 1'b0, 1, "a_up7");
    rst_a = 1'b1;
    set_a(1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
    ex(0, 8'd0, 1'b0, 1'b0, 1'b0, 1, "a_reset_wins");
    set_a(1'b1, 1'b1, 1'b1, 4'd15, 1'b1);
    ex(0, 8'd0, 1'b0, 1'b0, 1'b0, 1, "a_reset_over_bad_load");
    rst_a = 1'b0;
    set_a(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    ex(0, 8'd0, 1'b0, 1'b0, 1'b0, 1, "a_idle");

    // ---- saturating counter, MOD 13 ----
    ex(1, 8'd0, 1'b0, 1'b0, 1'b0, 1, "b_reset");
    rst_b = 1'b0;
    set_b(1'b0, 1'b1, 1'b1, 4'd11, 1'b1);
    ex(1, 8'd11, 1'b0, 1'b0, 1'b0, 1, "b_load11");
    set_b(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    ex(1, 8'd12, 1'b1, 1'b0, 1'b0, 1, "b_up12");
    for (int i = 0; i < 3; i++) begin
      ex(1, 8'd12, 1'b1, 1'b1, 1'b0, 1, "b_sat_hi");
    end
    set_b(1'b0, 1'b1, 1'b1, 4'd1, 1'b1);
    ex(1, 8'd1, 1'b0, 1'b0, 1'b0, 1, "b_load1");
    set_b(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    ex(1, 8'd0, 1'b1, 1'b0, 1'b0, 1, "b_dn0");
    for (int i = 0; i < 2; i++) begin
      ex(1, 8'd0, 1'b1, 1'b1, 1'b0, 1, "b_sat_lo");
    end
    set_b(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    ex(1, 8'd0, 1'b0, 1'b0, 1'b0, 1, "b_idle");

    // ---- MOD 16 cascade ----
    ex(2, 8'h00, 1'b0, 1'b0, 1'b0, 1, "c_reset");
    rst_c = 1'b0;
    if_lo.CountEn = 1'b1;
    for (int i = 0; i < 257; i++) begin
      ex(2, 8'((i + 1) % 256), ((i + 1) % 256) == 255, i == 255, 1'b0, 1, "c_cascade");
    end
    if_lo.CountEn = 1'b0;

    repeat (2) @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
